// File: rtl/bsg_bus_pack_gather_pkg.sv
// Shared types and sizing helpers for the bus pack/gather datapath.
package bsg_bus_pack_gather_pkg;

  typedef enum logic [1:0] {
    e_pack_repl = 2'd0,
    e_pack_zext = 2'd1,
    e_pack_sext = 2'd2
  } bsg_bus_pack_mode_e;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_gather = 2'd1,
    e_full   = 2'd2
  } bsg_bus_pack_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int bsg_width(input int x);
    return $clog2(x + 1);
  endfunction

  // Encoding 3 is a legal alias for zero-extension.
  function automatic bsg_bus_pack_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return e_pack_repl;
      2'd2:    return e_pack_sext;
      default: return e_pack_zext;
    endcase
  endfunction

endpackage

// File: rtl/bsg_bus_pack_extend.sv
// Combinational rotate-right by sel units, keep 2^size units, fill the rest by replicate/zero/sign.
// No state, no handshake; output follows inputs in the same cycle.
module bsg_bus_pack_extend
  import bsg_bus_pack_gather_pkg::*;
#(
  parameter int in_width_p   = 64,
  parameter int out_width_p  = 512,
  parameter int unit_width_p = 8,
  parameter int sel_width_p  = safe_clog2(in_width_p / unit_width_p),
  parameter int size_width_p = bsg_width(safe_clog2(out_width_p / unit_width_p))
) (
  input  logic [in_width_p-1:0]   data_i,
  input  logic [sel_width_p-1:0]  sel_i,
  input  logic [size_width_p-1:0] size_i,
  input  bsg_bus_pack_mode_e      mode_i,
  output logic [out_width_p-1:0]  data_o
);

  localparam int idx_width_lp = safe_clog2(out_width_p);

  int                        shamt;
  int                        req_bits;
  logic [in_width_p-1:0]     rot_beat;
  logic [out_width_p-1:0]    rot;
  logic [idx_width_lp-1:0]   mask;
  logic [idx_width_lp-1:0]   idx;

  // req_bits is a power of two, so tiling reduces to masking the bit index.
  always_comb begin
    shamt    = int'(sel_i) * unit_width_p;
    rot_beat = (data_i >> shamt) | (data_i << (in_width_p - shamt));
    rot      = out_width_p'(rot_beat);
    req_bits = unit_width_p << size_i;
    mask     = idx_width_lp'(req_bits - 1);
    idx      = '0;
    data_o   = '0;
    for (int i = 0; i < out_width_p; i++) begin
      idx = idx_width_lp'(i) & mask;
      if (i < req_bits) begin
        data_o[i] = rot[idx];
      end else begin
        case (mode_i)
          e_pack_repl: data_o[i] = rot[idx];
          e_pack_sext: data_o[i] = rot[mask];
          default:     data_o[i] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/bsg_bus_pack_gather.sv
// Gathers 1..out/in input beats into one extended out_width_p word; v_o rises the cycle after the last beat.
// In FULL the input is only accepted together with the output (ready_and_o = ready_and_i).
module bsg_bus_pack_gather
  import bsg_bus_pack_gather_pkg::*;
#(
  parameter int in_width_p   = 64,
  parameter int out_width_p  = 512,
  parameter int unit_width_p = 8,
  localparam int sel_width_lp  = safe_clog2(in_width_p / unit_width_p),
  localparam int size_width_lp = bsg_width(safe_clog2(out_width_p / unit_width_p))
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [in_width_p-1:0]    data_i,
  input  logic [sel_width_lp-1:0]  sel_i,
  input  logic [size_width_lp-1:0] size_i,
  input  logic [1:0]               mode_i,
  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic [out_width_p-1:0]   data_o
);

  localparam int slots_lp     = out_width_p / in_width_p;
  localparam int cnt_width_lp = safe_clog2(slots_lp) + 1;
  localparam logic [size_width_lp-1:0] max_size_lp = size_width_lp'($clog2(out_width_p / unit_width_p));
  localparam logic [size_width_lp-1:0] in_log_lp   = size_width_lp'($clog2(in_width_p / unit_width_p));

  bsg_bus_pack_state_e        state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [size_width_lp-1:0]   size_q, size_d;
  logic [sel_width_lp-1:0]    sel_q, sel_d;
  bsg_bus_pack_mode_e         mode_q, mode_d;
  logic [out_width_p-1:0]     data_q, data_d;
  logic [in_width_p-1:0]      slot_q [slots_lp];
  logic [in_width_p-1:0]      slot_d [slots_lp];

  logic                       accept, first, last, cur_narrow;
  logic [size_width_lp-1:0]   size_clamped, cur_size;
  logic [sel_width_lp-1:0]    cur_sel;
  bsg_bus_pack_mode_e         cur_mode;
  logic [cnt_width_lp-1:0]    beat_idx, cur_beats;
  logic [out_width_p-1:0]     gathered, narrow_ext, wide_ext;

  assign ready_and_o = (state_q == e_full) ? ready_and_i : 1'b1;
  assign v_o         = (state_q == e_full);
  assign data_o      = data_q;

  // Request fields come straight from the ports on a first beat, from the latches mid-gather.
  always_comb begin
    size_clamped = (size_i > max_size_lp) ? max_size_lp : size_i;
    accept       = v_i & ready_and_o;
    first        = (state_q != e_gather);
    cur_size     = first ? size_clamped : size_q;
    cur_sel      = first ? sel_i : sel_q;
    cur_mode     = first ? decode_mode(mode_i) : mode_q;
    cur_narrow   = (cur_size <= in_log_lp);
    cur_beats    = cur_narrow ? cnt_width_lp'(1) : (cnt_width_lp'(1) << (cur_size - in_log_lp));
    beat_idx     = first ? '0 : cnt_q;
    last         = accept && (beat_idx == cur_beats - cnt_width_lp'(1));
    gathered     = '0;
    for (int k = 0; k < slots_lp; k++) begin
      slot_d[k] = (accept && (beat_idx == cnt_width_lp'(k))) ? data_i : slot_q[k];
      gathered[k*in_width_p +: in_width_p] = slot_d[k];
    end
  end

  bsg_bus_pack_extend #(
    .in_width_p  (in_width_p),
    .out_width_p (out_width_p),
    .unit_width_p(unit_width_p),
    .sel_width_p (sel_width_lp),
    .size_width_p(size_width_lp)
  ) narrow_extend (
    .data_i(data_i),
    .sel_i (cur_sel),
    .size_i(cur_size),
    .mode_i(cur_mode),
    .data_o(narrow_ext)
  );

  bsg_bus_pack_extend #(
    .in_width_p  (out_width_p),
    .out_width_p (out_width_p),
    .unit_width_p(unit_width_p),
    .sel_width_p (1),
    .size_width_p(size_width_lp)
  ) wide_extend (
    .data_i(gathered),
    .sel_i (1'b0),
    .size_i(cur_size),
    .mode_i(cur_mode),
    .data_o(wide_ext)
  );

  // A beat accepted in FULL is only possible alongside the output handshake, so it starts a new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    data_d  = data_q;
    case (state_q)
      e_idle, e_full: begin
        if (accept) begin
          size_d  = size_clamped;
          sel_d   = sel_i;
          mode_d  = decode_mode(mode_i);
          state_d = last ? e_full : e_gather;
          cnt_d   = last ? '0 : cnt_width_lp'(1);
        end else if ((state_q == e_full) && ready_and_i) begin
          state_d = e_idle;
        end
      end
      e_gather: begin
        if (accept) begin
          if (last) begin
            state_d = e_full;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + cnt_width_lp'(1);
          end
        end
      end
      default: begin
        state_d = e_idle;
        cnt_d   = '0;
      end
    endcase
    if (last) begin
      data_d = cur_narrow ? narrow_ext : wide_ext;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      size_q  <= '0;
      sel_q   <= '0;
      mode_q  <= e_pack_repl;
      data_q  <= '0;
      for (int k = 0; k < slots_lp; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      slot_q  <= slot_d;
    end
  end

endmodule
